// File: rtl/magnitude_peak_detector.sv
// Windowed peak search over an unsigned magnitude stream: reports the largest
// sample of each WINDOW_LENGTH-sample window, its index and a threshold flag.
module magnitude_peak_detector #(
  parameter int DATA_WIDTH    = 18,
  parameter int WINDOW_LENGTH = 1024,
  parameter int INDEX_WIDTH   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  dataIn,
  input  logic [DATA_WIDTH-1:0]  threshold,
  output logic [DATA_WIDTH-1:0]  peakValue,
  output logic [INDEX_WIDTH-1:0] peakIndex,
  output logic                   detected,
  output logic                   peakValid
);

  typedef enum logic {IDLE, SEARCH} state_t;

  localparam logic [INDEX_WIDTH:0] LAST_COUNT = (INDEX_WIDTH+1)'(WINDOW_LENGTH - 1);
  localparam logic [INDEX_WIDTH:0] ONE_COUNT  = (INDEX_WIDTH+1)'(1);

  state_t                 state_reg, state_next;
  logic [DATA_WIDTH-1:0]  running_max_reg, running_max_next;
  logic [INDEX_WIDTH-1:0] running_index_reg, running_index_next;
  logic [INDEX_WIDTH:0]   sample_count_reg, sample_count_next;

  logic [DATA_WIDTH-1:0]  peak_value_reg;
  logic [INDEX_WIDTH-1:0] peak_index_reg;
  logic                   detected_reg;
  logic                   peak_valid_reg;

  // max/index including the sample accepted this cycle
  logic                   window_end;
  logic [DATA_WIDTH-1:0]  final_max;
  logic [INDEX_WIDTH-1:0] final_index;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      running_max_reg   <= '0;
      running_index_reg <= '0;
      sample_count_reg  <= '0;
    end else begin
      state_reg         <= state_next;
      running_max_reg   <= running_max_next;
      running_index_reg <= running_index_next;
      sample_count_reg  <= sample_count_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    running_max_next   = running_max_reg;
    running_index_next = running_index_reg;
    sample_count_next  = sample_count_reg;
    window_end         = 1'b0;
    final_max          = running_max_reg;
    final_index        = running_index_reg;

    case (state_reg)
      IDLE: begin
        if (enable) begin
          final_max          = dataIn;
          final_index        = '0;
          running_max_next   = dataIn;
          running_index_next = '0;
          sample_count_next  = ONE_COUNT;
          state_next         = SEARCH;
          if (WINDOW_LENGTH == 1) begin
            window_end        = 1'b1;
            sample_count_next = '0;
            state_next        = IDLE;
          end
        end
      end
      SEARCH: begin
        if (enable) begin
          // strict compare keeps the earliest index on ties
          if (dataIn > running_max_reg) begin
            final_max   = dataIn;
            final_index = sample_count_reg[INDEX_WIDTH-1:0];
          end
          running_max_next   = final_max;
          running_index_next = final_index;
          sample_count_next  = sample_count_reg + ONE_COUNT;
          if (sample_count_reg == LAST_COUNT) begin
            window_end        = 1'b1;
            sample_count_next = '0;
            state_next        = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      peak_value_reg <= '0;
      peak_index_reg <= '0;
      detected_reg   <= 1'b0;
      peak_valid_reg <= 1'b0;
    end else begin
      peak_valid_reg <= window_end;
      if (window_end) begin
        peak_value_reg <= final_max;
        peak_index_reg <= final_index;
        detected_reg   <= (final_max >= threshold);
      end
    end
  end

  assign peakValue = peak_value_reg;
  assign peakIndex = peak_index_reg;
  assign detected  = detected_reg;
  assign peakValid = peak_valid_reg;

endmodule

// File: tb/tb_magnitude_peak_detector.sv
// Directed bench for magnitude_peak_detector: a WINDOW_LENGTH=4 instance driven
// from a vector table plus hand sequences, and a WINDOW_LENGTH=1 instance.
module tb_magnitude_peak_detector;

  localparam int DW = 18;
  localparam int IW = 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          enable, enable1;
  logic [DW-1:0] dataIn, data1, threshold, thr1;
  logic [DW-1:0] peakValue, peakValue1;
  logic [IW-1:0] peakIndex, peakIndex1;
  logic          detected, detected1, peakValid, peakValid1;

  magnitude_peak_detector #(.DATA_WIDTH(DW), .WINDOW_LENGTH(4), .INDEX_WIDTH(IW)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .dataIn(dataIn), .threshold(threshold),
    .peakValue(peakValue), .peakIndex(peakIndex), .detected(detected), .peakValid(peakValid)
  );

  magnitude_peak_detector #(.DATA_WIDTH(DW), .WINDOW_LENGTH(1), .INDEX_WIDTH(IW)) dut_b (
    .clock(clock), .reset(reset), .enable(enable1), .dataIn(data1), .threshold(thr1),
    .peakValue(peakValue1), .peakIndex(peakIndex1), .detected(detected1), .peakValid(peakValid1)
  );

  typedef struct {
    logic          rst;
    logic          en;
    logic [DW-1:0] data;
    logic [DW-1:0] thr;
    logic          vld;
    logic [DW-1:0] val;
    logic [IW-1:0] idx;
    logic          det;
  } vec_t;

  vec_t vecs[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic vld, input logic [DW-1:0] val,
                         input logic [IW-1:0] idx, input logic det);
    check({tag, " peakValid"}, 32'(peakValid), 32'(vld));
    check({tag, " peakValue"}, 32'(peakValue), 32'(val));
    check({tag, " peakIndex"}, 32'(peakIndex), 32'(idx));
    check({tag, " detected"},  32'(detected),  32'(det));
  endtask

  task automatic check_b(input string tag, input logic vld, input logic [DW-1:0] val,
                         input logic [IW-1:0] idx, input logic det);
    check({tag, " peakValid1"}, 32'(peakValid1), 32'(vld));
    check({tag, " peakValue1"}, 32'(peakValue1), 32'(val));
    check({tag, " peakIndex1"}, 32'(peakIndex1), 32'(idx));
    check({tag, " detected1"},  32'(detected1),  32'(det));
  endtask

  // drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic r, input logic e, input logic [DW-1:0] d, input logic [DW-1:0] t);
    @(negedge clock);
    reset = r; enable = e; dataIn = d; threshold = t;
    @(posedge clock);
    #1;
    $display("A rst=%0b en=%0b data=0x%0h thr=0x%0h -> vld=%0b val=0x%0h idx=%0d det=%0b",
             r, e, d, t, peakValid, peakValue, peakIndex, detected);
  endtask

  task automatic step_b(input logic e, input logic [DW-1:0] d, input logic [DW-1:0] t);
    @(negedge clock);
    reset = 1'b0; enable = 1'b0; enable1 = e; data1 = d; thr1 = t;
    @(posedge clock);
    #1;
    $display("B en=%0b data=0x%0h thr=0x%0h -> vld=%0b val=0x%0h idx=%0d det=%0b",
             e, d, t, peakValid1, peakValue1, peakIndex1, detected1);
  endtask

  logic [DW-1:0] gap_data [4];

  initial begin
    reset = 1'b1; enable = 1'b0; dataIn = '0; threshold = '0;
    enable1 = 1'b0; data1 = '0; thr1 = '0;

    // reset, then test 1 (ties keep index 1), test 2 (below threshold), test 4 (back-to-back)
    vecs.push_back('{1'b1, 1'b0, 18'd0, 18'd0, 1'b0, 18'd0, 10'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 18'd0, 18'd0, 1'b0, 18'd0, 10'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 18'd3, 18'd8, 1'b0, 18'd0, 10'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 18'd9, 18'd8, 1'b0, 18'd0, 10'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 18'd9, 18'd8, 1'b0, 18'd0, 10'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 18'd2, 18'd8, 1'b1, 18'd9, 10'd1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 18'd0, 18'd8, 1'b0, 18'd9, 10'd1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 18'd5, 18'd8, 1'b0, 18'd9, 10'd1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 18'd1, 18'd8, 1'b0, 18'd9, 10'd1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 18'd7, 18'd8, 1'b0, 18'd9, 10'd1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 18'd6, 18'd8, 1'b1, 18'd7, 10'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 18'd0, 18'd8, 1'b0, 18'd7, 10'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 18'd1, 18'd4, 1'b0, 18'd7, 10'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 18'd2, 18'd4, 1'b0, 18'd7, 10'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 18'd3, 18'd4, 1'b0, 18'd7, 10'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 18'd4, 18'd4, 1'b1, 18'd4, 10'd3, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 18'd8, 18'd4, 1'b0, 18'd4, 10'd3, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 18'd7, 18'd4, 1'b0, 18'd4, 10'd3, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 18'd6, 18'd4, 1'b0, 18'd4, 10'd3, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 18'd5, 18'd4, 1'b1, 18'd8, 10'd0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 18'd0, 18'd4, 1'b0, 18'd8, 10'd0, 1'b1});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].data, vecs[i].thr);
      check_a($sformatf("vec%0d", i), vecs[i].vld, vecs[i].val, vecs[i].idx, vecs[i].det);
    end
    check_b("b idle after reset", 1'b0, 18'd0, 10'd0, 1'b0);

    // test 3: idle gaps, 0x20000 must outrank 0x1FFFF, tie keeps index 1
    gap_data[0] = 18'h1FFFF; gap_data[1] = 18'h20000;
    gap_data[2] = 18'h00000; gap_data[3] = 18'h20000;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, gap_data[k], 18'h20000);
      if (k < 3) begin
        check_a($sformatf("gap acc%0d", k), 1'b0, 18'd8, 10'd0, 1'b1);
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 18'h3FFFF, 18'h20000);
          check_a($sformatf("gap idle%0d_%0d", k, g), 1'b0, 18'd8, 10'd0, 1'b1);
        end
      end else begin
        check_a("gap report", 1'b1, 18'h20000, 10'd1, 1'b1);
      end
    end
    step(1'b0, 1'b0, 18'd0, 18'h20000);
    check_a("gap after", 1'b0, 18'h20000, 10'd1, 1'b1);

    // test 5: reset mid-window discards the partial window
    step(1'b0, 1'b1, 18'd20, 18'd4);
    check_a("rst pre20", 1'b0, 18'h20000, 10'd1, 1'b1);
    step(1'b0, 1'b1, 18'd30, 18'd4);
    check_a("rst pre30", 1'b0, 18'h20000, 10'd1, 1'b1);
    @(negedge clock);
    reset = 1'b1; enable = 1'b0;
    #1;
    check_a("rst async", 1'b0, 18'd0, 10'd0, 1'b0);
    @(posedge clock);
    #1;
    check_a("rst held", 1'b0, 18'd0, 10'd0, 1'b0);
    step(1'b0, 1'b0, 18'd0, 18'd4);
    check_a("rst release", 1'b0, 18'd0, 10'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 18'(k), 18'd4);
      if (k < 4) check_a($sformatf("rst win s%0d", k), 1'b0, 18'd0, 10'd0, 1'b0);
      else       check_a("rst win report", 1'b1, 18'd4, 10'd3, 1'b1);
    end
    step(1'b0, 1'b0, 18'd0, 18'd4);
    check_a("rst win after", 1'b0, 18'd4, 10'd3, 1'b1);

    // test 6: WINDOW_LENGTH=1 reports every accepted sample
    check_b("b after reset", 1'b0, 18'd0, 10'd0, 1'b0);
    step_b(1'b1, 18'd7, 18'd5);
    check_b("b s7", 1'b1, 18'd7, 10'd0, 1'b1);
    step_b(1'b1, 18'd3, 18'd5);
    check_b("b s3", 1'b1, 18'd3, 10'd0, 1'b0);
    step_b(1'b0, 18'd9, 18'd5);
    check_b("b idle", 1'b0, 18'd3, 10'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
